// File: rtl/ysyx_ifu_fetch_queue.sv
// IFU fetch queue: in-order circular buffer between the I-cache/MMU
// response path and the IDU handshake. Holds inst, pc, predicted next pc
// and fetch-trap info per entry; the whole queue is dropped on flush_pipe.
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif

module ysyx_ifu_fetch_queue #(
  parameter int XLEN  = `YSYX_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_pipe,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc,
  input  logic [XLEN-1:0] in_pnpc,
  input  logic            in_trap,
  input  logic [XLEN-1:0] in_cause,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [31:0]     out_pc,
  output logic [XLEN-1:0] out_pnpc,
  output logic            out_trap,
  output logic [XLEN-1:0] out_cause
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  // Payload storage; never reset, outputs are masked while empty.
  logic [31:0]     q_inst  [DEPTH];
  logic [31:0]     q_pc    [DEPTH];
  logic [XLEN-1:0] q_pnpc  [DEPTH];
  logic            q_trap  [DEPTH];
  logic [XLEN-1:0] q_cause [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          nonempty, push, pop;

  // A full queue refuses pushes even when a pop happens in the same cycle,
  // keeping in_ready purely a function of state.
  assign nonempty  = (count != '0);
  assign in_ready  = (count != CNT_FULL);
  assign out_valid = nonempty && !flush_pipe;
  assign push      = in_valid && in_ready && !flush_pipe;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy tracking; flush empties the queue outright.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_pipe) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Write the accepted response into the tail slot.
  always_ff @(posedge clock) begin
    if (push) begin
      q_inst[tail]  <= in_inst;
      q_pc[tail]    <= in_pc;
      q_pnpc[tail]  <= in_pnpc;
      q_trap[tail]  <= in_trap;
      q_cause[tail] <= in_cause;
    end
  end

  // Present the head entry, or all zeros when empty so no X escapes.
  always_comb begin
    out_inst  = '0;
    out_pc    = '0;
    out_pnpc  = '0;
    out_trap  = 1'b0;
    out_cause = '0;
    if (nonempty) begin
      out_inst  = q_inst[head];
      out_pc    = q_pc[head];
      out_pnpc  = q_pnpc[head];
      out_trap  = q_trap[head];
      out_cause = q_cause[head];
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_fetch_queue.sv
// Bench for ysyx_ifu_fetch_queue: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_ysyx_ifu_fetch_queue;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush_pipe, in_valid, in_ready, in_trap;
  logic [31:0]     in_inst, in_pc;
  logic [XLEN-1:0] in_pnpc, in_cause;
  logic            out_valid, out_ready, out_trap;
  logic [31:0]     out_inst, out_pc;
  logic [XLEN-1:0] out_pnpc, out_cause;

  ysyx_ifu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush_pipe(flush_pipe),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_pnpc(in_pnpc), .in_trap(in_trap), .in_cause(in_cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pnpc(out_pnpc), .out_trap(out_trap),
    .out_cause(out_cause)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]     inst;
    logic [31:0]     pc;
    logic [XLEN-1:0] pnpc;
    logic            trap;
    logic [XLEN-1:0] cause;
  } ent_t;

  ent_t mq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic t, logic [63:0] c,
                       logic rdy, logic fl);
    in_valid   = v;
    in_pc      = pc;
    in_inst    = $urandom;
    in_pnpc    = {$urandom, $urandom};
    in_trap    = t;
    in_cause   = c;
    out_ready  = rdy;
    flush_pipe = fl;
  endtask

  // Called just after a falling edge with inputs set: check, step model, advance.
  task automatic cycle();
    ent_t e;
    bit   ne, ev, acc;
    #1;
    ne = (mq.size() != 0);
    ev = ne && !flush_pipe;
    if (ne) e = mq[0];
    else    e = '{inst: '0, pc: '0, pnpc: '0, trap: 1'b0, cause: '0};
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
    chk("count",     64'(dut.count), 64'(mq.size()));
    chk("out_inst",  64'(out_inst),  64'(e.inst));
    chk("out_pc",    64'(out_pc),    64'(e.pc));
    chk("out_pnpc",  out_pnpc,       e.pnpc);
    chk("out_trap",  64'(out_trap),  64'(e.trap));
    chk("out_cause", out_cause,      e.cause);
    acc = in_valid && (mq.size() != DEPTH) && !flush_pipe;
    if (flush_pipe) mq.delete();
    else begin
      if (ev && out_ready) mq.delete(0);
      if (acc) mq.push_back('{inst: in_inst, pc: in_pc, pnpc: in_pnpc,
                              trap: in_trap, cause: in_cause});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reset asserted between edges must clear the queue immediately.
  task automatic async_rst();
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    mq.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset state, then single push of addi x0,x0,0
    drive(0, 0, 0, 0, 1, 0); cycle();
    drive(1, 32'h8000_0000, 0, 0, 1, 0); in_inst = 32'h0000_0013; cycle();
    drive(0, 0, 0, 0, 1, 0); cycle();
    chk("single_drained", 64'(mq.size()), 64'd0);
    cycle();

    // fill with out_ready=0, fifth word refused, head stays stable
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h8000_1000 + 32'(4*i), 0, 0, 0, 0); cycle();
    end
    chk("full_model", 64'(mq.size()), 64'(DEPTH));
    // full with simultaneous pop and push: pop only
    drive(1, 32'h8000_2000, 0, 0, 1, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    repeat (DEPTH) begin drive(0, 0, 0, 0, 1, 0); cycle(); end

    // stream 10 words through pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h8000_0000 + 32'(4*i), 0, 0, 1, 0); cycle();
    end
    repeat (2) begin drive(0, 0, 0, 0, 1, 0); cycle(); end

    // flush with 3 queued and a push in the flush cycle
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h8000_3000 + 32'(4*i), 0, 0, 0, 0); cycle();
    end
    drive(1, 32'h8000_3100, 0, 0, 1, 1); cycle();
    drive(0, 0, 0, 0, 1, 0); cycle();
    drive(1, 32'h8000_4000, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 1, 0); cycle();
    cycle();

    // trap entry between two normal words
    drive(1, 32'h8000_5000, 0, 64'd0, 0, 0); cycle();
    drive(1, 32'h8000_5004, 1, 64'd12, 0, 0); cycle();
    drive(1, 32'h8000_5008, 0, 64'd0, 0, 0); cycle();
    repeat (4) begin drive(0, 0, 0, 0, 1, 0); cycle(); end

    // async reset with entries queued
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h8000_6000 + 32'(4*i), 0, 0, 0, 0); cycle();
    end
    async_rst();
    drive(0, 0, 0, 0, 1, 0); cycle();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
            {$urandom, $urandom}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
      if (i == 700) async_rst();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
